// File: rtl/alu_serial_pkg.sv
// Shared encodings for the digit-serial ALU: mode/opsel constants, FSM states, status flags.
package alu_serial_pkg;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_PASA = 3'b110;
  localparam logic [2:0] OP_NEG  = 3'b111;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_PASB = 3'b110;
  localparam logic [2:0] OP_NAND = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

  // Carry fed into digit 0; subtract/increment/negate get their +1 here.
  function automatic logic seed_carry(input logic mode, input logic [2:0] opsel, input logic cin);
    logic s;
    s = 1'b0;
    if (mode == MODE_ARITH) begin
      case (opsel)
        OP_ADC, OP_SBC:         s = cin;
        OP_SUB, OP_INC, OP_NEG: s = 1'b1;
        default:                s = 1'b0;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-bit arithmetic/logic slice; operand inversions are done here, carry-in comes from outside.
module alu_digit
  import alu_serial_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             mode,
  input  logic [2:0]       opsel,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT-1:0] ax, bx;
  logic             c;

  always_comb begin
    ax   = a;
    bx   = b;
    sum  = '0;
    cout = 1'b0;
    cmsb = 1'b0;
    c    = cin;
    if (mode == MODE_ARITH) begin
      case (opsel)
        OP_SUB, OP_SBC:  bx = ~b;
        OP_INC, OP_PASA: bx = '0;
        OP_DEC:          bx = '1;
        OP_NEG: begin
          ax = ~a;
          bx = '0;
        end
        default:         bx = b;
      endcase
      for (int i = 0; i < DIGIT; i++) begin
        if (i == DIGIT - 1) cmsb = c;
        sum[i] = ax[i] ^ bx[i] ^ c;
        c      = (ax[i] & bx[i]) | (ax[i] & c) | (bx[i] & c);
      end
      cout = c;
    end else begin
      case (opsel)
        OP_AND:  sum = a & b;
        OP_OR:   sum = a | b;
        OP_XOR:  sum = a ^ b;
        OP_NOT:  sum = ~a;
        OP_PASB: sum = b;
        OP_NAND: sum = ~(a & b);
        default: sum = a;  // shifts arrive pre-shifted on a
      endcase
    end
  end

endmodule

// File: rtl/alu_serial_nbit.sv
// Digit-serial N-bit ALU: latches the request, runs WIDTH/DIGIT digit steps LSB first, then holds result/flags until accepted.
module alu_serial_nbit
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  input  logic             mode,
  input  logic [2:0]       opsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int NUM_STEPS = WIDTH / DIGIT;
  localparam int SW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  state_e           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] a_q, b_q, res_acc_q, result_q;
  logic             cin_q, mode_q, carry_q, zacc_q;
  logic [2:0]       opsel_q;
  flags_t           flags_q, fin;

  logic             accept, last;
  logic [WIDTH-1:0] a_src, a_sh, b_sh, res_next;
  logic [DIGIT-1:0] sum;
  logic             cout, cmsb;

  assign accept = in_valid && (state_q == S_IDLE);
  assign last   = (step_q == SW'(NUM_STEPS - 1));

  // Shifts consume the whole latched word, so the slice just passes a pre-shifted copy.
  always_comb begin
    a_src = a_q;
    if (mode_q == MODE_LOGIC && opsel_q == OP_SHL) a_src = {a_q[WIDTH-2:0], cin_q};
    if (mode_q == MODE_LOGIC && opsel_q == OP_SHR) a_src = {cin_q, a_q[WIDTH-1:1]};
  end

  assign a_sh     = a_src >> (int'(step_q) * DIGIT);
  assign b_sh     = b_q >> (int'(step_q) * DIGIT);
  assign res_next = res_acc_q | (WIDTH'(sum) << (int'(step_q) * DIGIT));

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry_q),
    .mode  (mode_q),
    .opsel (opsel_q),
    .sum   (sum),
    .cout  (cout),
    .cmsb  (cmsb)
  );

  always_comb begin
    fin.z = zacc_q & (sum == '0);
    fin.n = res_next[WIDTH-1];
    fin.c = 1'b0;
    fin.v = 1'b0;
    if (mode_q == MODE_ARITH) begin
      if (opsel_q != OP_PASA) begin
        fin.c = cout;
        fin.v = cmsb ^ cout;
      end
    end else if (opsel_q == OP_SHL) begin
      fin.c = a_q[WIDTH-1];
    end else if (opsel_q == OP_SHR) begin
      fin.c = a_q[0];
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_RUN;
        step_d  = '0;
      end
      S_RUN: begin
        step_d = step_q + SW'(1);
        if (last) begin
          state_d = S_DONE;
          step_d  = '0;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      mode_q    <= 1'b0;
      opsel_q   <= '0;
      carry_q   <= 1'b0;
      zacc_q    <= 1'b0;
      res_acc_q <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else if (accept) begin
      a_q       <= op1;
      b_q       <= op2;
      cin_q     <= cin;
      mode_q    <= mode;
      opsel_q   <= opsel;
      carry_q   <= seed_carry(mode, opsel, cin);
      zacc_q    <= 1'b1;
      res_acc_q <= '0;
    end else if (state_q == S_RUN) begin
      carry_q   <= cout;
      zacc_q    <= fin.z;
      res_acc_q <= res_next;
      if (last) begin
        result_q <= res_next;
        flags_q  <= fin;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flag_c    = flags_q.c;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_serial_nbit.sv
// Self-checking bench for alu_serial_nbit (WIDTH=8, DIGIT=2) against a word-level arithmetic model.
module tb_alu_serial_nbit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, cin, mode, out_valid, out_ready;
  logic [7:0] op1, op2, result;
  logic [2:0] opsel;
  logic       flag_c, flag_z, flag_n, flag_v;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;  // {c,z,n,v}
  } exp_t;

  alu_serial_nbit #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .cin(cin), .mode(mode), .opsel(opsel),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                                 input logic m, input logic [2:0] o);
    exp_t e;
    logic [7:0] x, y, lo;
    logic [8:0] full;
    logic c0, c, v;
    x = a; y = b; c0 = 1'b0; c = 1'b0; v = 1'b0;
    if (m == 1'b0) begin
      case (o)
        3'd0: begin y = b;     c0 = 1'b0; end
        3'd1: begin y = b;     c0 = ci;   end
        3'd2: begin y = ~b;    c0 = 1'b1; end
        3'd3: begin y = ~b;    c0 = ci;   end
        3'd4: begin y = 8'h00; c0 = 1'b1; end
        3'd5: begin y = 8'hFF; c0 = 1'b0; end
        3'd6: begin y = 8'h00; c0 = 1'b0; end
        default: begin x = ~a; y = 8'h00; c0 = 1'b1; end
      endcase
      full = {1'b0, x} + {1'b0, y} + {8'h00, c0};
      lo   = {1'b0, x[6:0]} + {1'b0, y[6:0]} + {7'h00, c0};
      e.r  = full[7:0];
      c    = full[8];
      v    = lo[7] ^ full[8];
      if (o == 3'd6) begin e.r = a; c = 1'b0; v = 1'b0; end
    end else begin
      case (o)
        3'd0: e.r = a & b;
        3'd1: e.r = a | b;
        3'd2: e.r = a ^ b;
        3'd3: e.r = ~a;
        3'd4: begin e.r = {a[6:0], ci}; c = a[7]; end
        3'd5: begin e.r = {ci, a[7:1]}; c = a[0]; end
        3'd6: e.r = b;
        default: e.r = ~(a & b);
      endcase
    end
    e.f = {c, (e.r == 8'h00), e.r[7], v};
    return e;
  endfunction

  // Drives one request and waits (bounded) for out_valid; out_ready is left to the caller.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic m, input logic [2:0] o, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    op1 = a; op2 = b; cin = ci; mode = m; opsel = o; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (!out_valid) begin
      errs++;
      $display("FAIL timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; cin = 1'b0; mode = 1'b0; opsel = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, result, flag_c, flag_z, flag_n, flag_v} !== 13'h0) begin
      errs++;
      $display("FAIL reset_outputs: got ov=%0b res=%h f=%b, required all 0",
               out_valid, result, {flag_c, flag_z, flag_n, flag_v});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [7:0] va [6] = '{8'h7F, 8'h10, 8'hFF, 8'h81, 8'h81, 8'hF0};
    logic [7:0] vb [6] = '{8'h01, 8'h20, 8'h01, 8'h00, 8'h00, 8'h3C};
    logic       vm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] vo [6] = '{3'd0, 3'd2, 3'd0, 3'd4, 3'd5, 3'd0};
    logic       vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      e = model(va[i], vb[i], vc[i], vm[i], vo[i]);
      run_op(va[i], vb[i], vc[i], vm[i], vo[i], lat);
      checks++;
      if (result !== e.r || {flag_c, flag_z, flag_n, flag_v} !== e.f) begin
        errs++;
        $display("FAIL directed[%0d]: got res=%h f=%b, required res=%h f=%b",
                 i, result, {flag_c, flag_z, flag_n, flag_v}, e.r, e.f);
      end
      checks++;
      if (lat != 4) begin
        errs++;
        $display("FAIL latency[%0d]: got %0d, required 4", i, lat);
      end
      release_out();
    end
    // ADD 0x7F+0x01 pinned to literal values as well as the model
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 3'd0, lat);
    checks++;
    if (result !== 8'h80 || {flag_c, flag_z, flag_n, flag_v} !== 4'b0011) begin
      errs++;
      $display("FAIL add_7f_01: got res=%h f=%b, required res=80 f=0011",
               result, {flag_c, flag_z, flag_n, flag_v});
    end
    release_out();
  endtask

  task automatic test_random();
    exp_t e;
    int lat;
    logic [7:0] a, b;
    logic ci, m;
    logic [2:0] o;
    for (int i = 0; i < 48; i++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      m = 1'(i / 8); o = 3'(i % 8);
      if (i >= 16) begin m = 1'($urandom); o = 3'($urandom); end
      e = model(a, b, ci, m, o);
      out_ready = 1'b1;
      run_op(a, b, ci, m, o, lat);
      checks++;
      if (result !== e.r || {flag_c, flag_z, flag_n, flag_v} !== e.f) begin
        errs++;
        $display("FAIL random[%0d] m=%0b o=%0d a=%h b=%h ci=%0b: got res=%h f=%b, required res=%h f=%b",
                 i, m, o, a, b, ci, result, {flag_c, flag_z, flag_n, flag_v}, e.r, e.f);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    e = model(8'h10, 8'h20, 1'b0, 1'b0, 3'd2);
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 3'd2, lat);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; op1 = 8'($urandom); op2 = 8'($urandom); opsel = 3'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.r ||
          {flag_c, flag_z, flag_n, flag_v} !== e.f) begin
        errs++;
        $display("FAIL backpressure[%0d]: got ov=%b ir=%b res=%h f=%b, required ov=1 ir=0 res=%h f=%b",
                 k, out_valid, in_ready, result, {flag_c, flag_z, flag_n, flag_v}, e.r, e.f);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL release: got ov=%b ir=%b, required ov=0 ir=1", out_valid, in_ready);
    end
    lat = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) lat++; end
    checks++;
    if (lat != 0) begin
      errs++;
      $display("FAIL no_queue: out_valid high %0d cycles, required 0", lat);
    end
  endtask

  task automatic test_latch();
    int lat;
    op1 = 8'h12; op2 = 8'h34; cin = 1'b0; mode = 1'b0; opsel = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    op1 = 8'hFF; op2 = 8'h00; opsel = 3'd2; mode = 1'b1; cin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_valid !== 1'b1 || result !== 8'h46 || {flag_c, flag_z, flag_n, flag_v} !== 4'b0000) begin
      errs++;
      $display("FAIL latch: got ov=%b res=%h f=%b, required ov=1 res=46 f=0000",
               out_valid, result, {flag_c, flag_z, flag_n, flag_v});
    end
    release_out();
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int lat, pulses;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 3'd0, lat);
    release_out();
    op1 = 8'h55; op2 = 8'h66; cin = 1'b0; mode = 1'b0; opsel = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, result, flag_c, flag_z, flag_n, flag_v} !== 13'h0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL abort_outputs: got ov=%b res=%h f=%b ir=%b, required all 0, ir=1",
               out_valid, result, {flag_c, flag_z, flag_n, flag_v}, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) pulses++; end
    checks++;
    if (pulses != 0) begin
      errs++;
      $display("FAIL abort_pulse: out_valid high %0d cycles, required 0", pulses);
    end
    e = model(8'h01, 8'h01, 1'b1, 1'b0, 3'd1);
    run_op(8'h01, 8'h01, 1'b1, 1'b0, 3'd1, lat);
    checks++;
    if (result !== 8'h03 || result !== e.r || {flag_c, flag_z, flag_n, flag_v} !== e.f) begin
      errs++;
      $display("FAIL adc_after_reset: got res=%h f=%b, required res=03 f=%b",
               result, {flag_c, flag_z, flag_n, flag_v}, e.f);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_latch();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
